bpu_gshare_btb: RTL and testbench
=================================

Name: bpu_gshare_btb

Overview:
Parametrised next-generation branch prediction unit for the Aquila RISC-V core. It pairs a fully associative branch target buffer (BTB) of ENTRY_NUM entries with a gshare pattern history table (PHT) of 2-bit saturating counters, indexed by PC bits XOR a real global history register (GHR). It serves the Program_Counter with a same-cycle prediction. The PHT index is pipelined from Fetch to Execute so that the counter read at prediction time is the counter trained at resolution. All tables train from resolved Execute results.

Parameters:
XLEN, 32, address/data width
ENTRY_NUM, 64, BTB entries (power of 2, 4..256)
PHT_ENTRIES, 1024, PHT counters (power of 2, 16..4096); PHT_W = clog2(PHT_ENTRIES)
GHR_LEN, 8, global history bits (1..PHT_W)
PC_LSB, 2, lowest PC bit used in the PHT index

Ports:
clk_i  in  1  single clock
rst_ni  in  1  reset; asynchronous, active-low
stall_i  in  1  pipeline stall; freezes all state
flush_i  in  1  squash in-flight Fetch/Decode index stages
pc_i  in  XLEN  Fetch PC
dec_is_branch_i  in  1  instruction at Decode is a cond branch or jal
exe_is_branch_i  in  1  resolved branch or jal at Execute
exe_is_jal_i  in  1  the Execute instruction is jal
exe_pc_i  in  XLEN  PC of the Execute instruction
branch_taken_i  in  1  resolved direction
branch_misprediction_i  in  1  Execute detected a mispredict
branch_target_addr_i  in  XLEN  resolved target
branch_hit_o  out  1  BTB hit for pc_i
branch_decision_o  out  1  predict taken
branch_target_addr_o  out  XLEN  predicted target (0 on miss)
perf_cond_cnt_o  out  32  resolved conditional branches
perf_miss_cnt_o  out  32  conditional mispredicts
perf_btb_alloc_o  out  32  BTB allocations

Behaviour:
- Reset is asynchronous and active-low. It is one clock; all state clears on rst_ni=0 regardless of stall_i:
  - BTB valid bits 0.
  - Replacement pointer 0.
  - GHR 0.
  - PHT counters 2'b01 (weakly not-taken).
  - Index pipe valids 0.
  - Perf counters 0.
  - All outputs read 0 while in reset.
- Lookup is combinational, 0-cycle:
  - hit = any valid entry whose tag == pc_i, and pc_i != 0.
  - idx_f = pc_i[PC_LSB +: PHT_W] XOR zero-extended GHR.
  - branch_decision_o = hit & (entry.jal | PHT[idx_f][1]).
  - branch_target_addr_o = hit ? entry.target : 0.
- Index pipe: when ~stall_i, the Fetch-stage index and hit advance to the Decode stage, then to the Execute stage; the tag is {idx, valid}.
  - flush_i with ~stall_i invalidates the Fetch and Decode stages next cycle.
  - flush_i takes priority over the advance.
- Training happens only when ~stall_i & exe_is_branch_i.
  - Conditional (~exe_is_jal_i), with a valid Execute stage: PHT[idx_e] saturates 00->01->10->11 on taken and 11->10->01->00 on not-taken.
  - Conditional with an invalid Execute stage: recompute the index from exe_pc_i XOR current GHR.
  - Conditional: GHR <= {GHR[GHR_LEN-2:0], branch_taken_i}.
  - jal: no PHT or GHR change.
  - BTB miss on exe_pc_i, when taken or jal: allocate the entry at the pointer with {valid=1, tag=exe_pc_i, target=branch_target_addr_i, jal=exe_is_jal_i}. The pointer then increments and wraps ENTRY_NUM-1 -> 0, overwriting the oldest entry.
  - BTB hit with a differing target: rewrite the target in place; the pointer does not move.
- Simultaneous events:
  - Training and lookup of the same PHT index or BTB entry in the same cycle: lookup returns the pre-update value, with no bypass. The new value is visible next cycle.
  - Allocation of a tag equal to pc_i: the lookup misses this cycle and hits next cycle.
  - stall_i=1 holds the BTB, PHT, GHR, pointer, pipe and counters; outputs still track pc_i.
- dec_is_branch_i is used only to gate the BTB-hit statistic. Allocation happens at Execute, so a not-taken first execution never allocates.

Optional Feature:
BPU_PERF_CNT_EN.
- Defined: three 32-bit wrapping counters, incremented on ~stall_i:
  - cond_cnt on a resolved conditional branch.
  - miss_cnt when that branch also has branch_misprediction_i.
  - btb_alloc on each allocation.
- Undefined: counter logic is not instantiated and the three perf ports are tied to 0.

Decomposition:
- Package bpu_pkg holds the counter encoding localparams (SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11), the PHT reset value, and the BTB entry struct/field widths.
- Sub-module bpu_btb holds the tag match, the priority encoder (lowest index wins), the replacement pointer and the target storage. It is generic over ENTRY_NUM and replaces the hand-written case decoder.

Test Plan:
- Reset, then pc_i=0x100: hit=0, decision=0, target=0. Assert rst_ni low mid-run: the next lookup of a previously allocated PC misses.
- Resolve taken cond at exe_pc=0x200, target 0x240: next cycle pc_i=0x200 gives hit=1, target=0x240. Decision=0 (counter 01->10, GHR=1, index changes).
- Loop branch at 0x300, taken 7 times then not-taken, repeated for 4 iterations with GHR_LEN=8: mispredicts in the 4th iteration ≤1 (gshare learns the exit).
- Allocate ENTRY_NUM+1 distinct taken jal PCs 0x1000+4k: the first PC misses, PC k=1 still hits, and perf_btb_alloc=65.
- stall_i=1 for 5 cycles during an exe_is_branch_i pulse: no counter, GHR or BTB change. A flush_i pulse invalidates the pipe, and the next Execute training uses the recomputed index.
- With BPU_PERF_CNT_EN: 10 cond branches with 3 mispredicts give cond=10, miss=3. Without the macro, all perf ports read 0.

Source files
------------

// File: rtl/bpu_pkg.sv
// bpu_pkg: counter encodings, PHT reset value and BTB entry control bits
// shared by the gshare/BTB branch predictor.
package bpu_pkg;

   localparam logic [1:0] SNT     = 2'b00;
   localparam logic [1:0] WNT     = 2'b01;
   localparam logic [1:0] WT      = 2'b10;
   localparam logic [1:0] ST      = 2'b11;
   localparam logic [1:0] PHT_RST = WNT;

   // Control bits of one BTB entry; tag and target are XLEN wide in bpu_btb.
   typedef struct packed {
      logic valid;
      logic jal;
   } btb_meta_t;

   // 2-bit saturating counter step.
   function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      case (ctr)
         SNT:     nxt = taken ? WNT : SNT;
         WNT:     nxt = taken ? WT  : SNT;
         WT:      nxt = taken ? ST  : WNT;
         ST:      nxt = taken ? ST  : WT;
         default: nxt = PHT_RST;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/bpu_btb.sv
// bpu_btb: fully associative branch target buffer with FIFO replacement.
// Lowest matching index wins; allocation happens only on a taken/jal miss.
module bpu_btb
   import bpu_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned ENTRY_NUM = 64
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [XLEN-1:0] lkp_pc_i,
   output logic            lkp_hit_o,
   output logic            lkp_jal_o,
   output logic [XLEN-1:0] lkp_target_o,
   input  logic            upd_en_i,
   input  logic [XLEN-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic            upd_jal_i,
   input  logic [XLEN-1:0] upd_target_i,
   output logic            alloc_o
);

   localparam int unsigned PTR_W = $clog2(ENTRY_NUM);

   btb_meta_t        meta_q [ENTRY_NUM];
   logic [XLEN-1:0]  tag_q  [ENTRY_NUM];
   logic [XLEN-1:0]  tgt_q  [ENTRY_NUM];
   logic [PTR_W-1:0] ptr_q, ptr_d;

   logic             upd_hit;
   logic [PTR_W-1:0] upd_idx;
   logic             lkp_found;

   // Fetch-side lookup: lowest valid matching entry; PC 0 never hits.
   always_comb begin
      lkp_found    = 1'b0;
      lkp_jal_o    = 1'b0;
      lkp_target_o = '0;
      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
         if (!lkp_found && meta_q[i].valid && (tag_q[i] == lkp_pc_i)) begin
            lkp_found    = 1'b1;
            lkp_jal_o    = meta_q[i].jal;
            lkp_target_o = tgt_q[i];
         end
      end
      lkp_hit_o = lkp_found && (lkp_pc_i != '0);
      if (!lkp_hit_o) begin
         lkp_jal_o    = 1'b0;
         lkp_target_o = '0;
      end
   end

   // Execute-side match used to choose between allocate and target rewrite.
   always_comb begin
      upd_hit = 1'b0;
      upd_idx = '0;
      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
         if (!upd_hit && meta_q[i].valid && (tag_q[i] == upd_pc_i)) begin
            upd_hit = 1'b1;
            upd_idx = PTR_W'(i);
         end
      end
   end

   assign alloc_o = upd_en_i && !upd_hit && (upd_taken_i || upd_jal_i);

   // Replacement pointer advances only on allocation and wraps naturally.
   always_comb begin
      ptr_d = ptr_q;
      if (alloc_o) ptr_d = ptr_q + PTR_W'(1);
   end

   // Entry storage: allocate at the pointer, or retarget a hit in place.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            meta_q[i] <= '0;
            tag_q[i]  <= '0;
            tgt_q[i]  <= '0;
         end
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         if (alloc_o) begin
            meta_q[ptr_q] <= btb_meta_t'{valid: 1'b1, jal: upd_jal_i};
            tag_q[ptr_q]  <= upd_pc_i;
            tgt_q[ptr_q]  <= upd_target_i;
         end else if (upd_en_i && upd_hit && (tgt_q[upd_idx] != upd_target_i)) begin
            tgt_q[upd_idx] <= upd_target_i;
         end
      end
   end

endmodule

// File: rtl/bpu_gshare_btb.sv
// bpu_gshare_btb: gshare PHT + fully associative BTB, same-cycle prediction.
// The PHT index is carried Fetch->Decode->Execute so training hits the
// counter that produced the prediction. Optional statistics counters are
// built when BPU_PERF_CNT_EN is defined; otherwise the perf ports read 0.
module bpu_gshare_btb
   import bpu_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned ENTRY_NUM   = 64,
   parameter int unsigned PHT_ENTRIES = 1024,
   parameter int unsigned GHR_LEN     = 8,
   parameter int unsigned PC_LSB      = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic            dec_is_branch_i,
   input  logic            exe_is_branch_i,
   input  logic            exe_is_jal_i,
   input  logic [XLEN-1:0] exe_pc_i,
   input  logic            branch_taken_i,
   input  logic            branch_misprediction_i,
   input  logic [XLEN-1:0] branch_target_addr_i,
   output logic            branch_hit_o,
   output logic            branch_decision_o,
   output logic [XLEN-1:0] branch_target_addr_o,
   output logic [31:0]     perf_cond_cnt_o,
   output logic [31:0]     perf_miss_cnt_o,
   output logic [31:0]     perf_btb_alloc_o
);

   localparam int unsigned PHT_W = $clog2(PHT_ENTRIES);

   logic [1:0]         pht_q [PHT_ENTRIES];
   logic [GHR_LEN-1:0] ghr_q, ghr_d;
   logic [PHT_W-1:0]   idx_f, idx_d_q, idx_e_q, idx_trn;
   logic               vld_d_q, vld_e_q, hit_d_q, hit_e_q;
   logic               btb_hit, btb_jal, btb_alloc;
   logic               trn_en, cond_trn;
   logic               unused_stat;

   bpu_btb #(
      .XLEN      (XLEN),
      .ENTRY_NUM (ENTRY_NUM)
   ) u_btb (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .lkp_pc_i     (pc_i),
      .lkp_hit_o    (btb_hit),
      .lkp_jal_o    (btb_jal),
      .lkp_target_o (branch_target_addr_o),
      .upd_en_i     (trn_en),
      .upd_pc_i     (exe_pc_i),
      .upd_taken_i  (branch_taken_i),
      .upd_jal_i    (exe_is_jal_i),
      .upd_target_i (branch_target_addr_i),
      .alloc_o      (btb_alloc)
   );

   assign idx_f             = pc_i[PC_LSB +: PHT_W] ^ PHT_W'(ghr_q);
   assign branch_hit_o      = btb_hit;
   assign branch_decision_o = btb_hit && (btb_jal || pht_q[idx_f][1]);

   assign trn_en   = !stall_i && exe_is_branch_i;
   assign cond_trn = trn_en && !exe_is_jal_i;
   // A squashed Execute slot has no carried index, so rebuild it from the
   // resolved PC and the history as it stands now.
   assign idx_trn  = vld_e_q ? idx_e_q : (exe_pc_i[PC_LSB +: PHT_W] ^ PHT_W'(ghr_q));

   // Global history shifts in each resolved conditional outcome.
   always_comb begin
      ghr_d = ghr_q;
      if (cond_trn) ghr_d = GHR_LEN'({ghr_q, branch_taken_i});
   end

   // History register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ghr_q <= '0;
      else         ghr_q <= ghr_d;
   end

   // Pattern history table: trained only by resolved conditional branches.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= PHT_RST;
      end else if (cond_trn) begin
         pht_q[idx_trn] <= ctr_update(pht_q[idx_trn], branch_taken_i);
      end
   end

   // Index pipe; flush squashes the Fetch and Decode slots ahead of advance.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_d_q <= '0;
         idx_e_q <= '0;
         vld_d_q <= 1'b0;
         vld_e_q <= 1'b0;
         hit_d_q <= 1'b0;
         hit_e_q <= 1'b0;
      end else if (!stall_i) begin
         idx_d_q <= idx_f;
         idx_e_q <= idx_d_q;
         hit_d_q <= btb_hit;
         hit_e_q <= hit_d_q;
         if (flush_i) begin
            vld_d_q <= 1'b0;
            vld_e_q <= 1'b0;
         end else begin
            vld_d_q <= 1'b1;
            vld_e_q <= vld_d_q;
         end
      end
   end

`ifdef BPU_PERF_CNT_EN
   logic [31:0] cond_cnt_q, miss_cnt_q, alloc_cnt_q;

   // Wrapping statistics on resolved conditionals, mispredicts and allocations.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cond_cnt_q  <= '0;
         miss_cnt_q  <= '0;
         alloc_cnt_q <= '0;
      end else begin
         if (cond_trn)                           cond_cnt_q  <= cond_cnt_q + 32'd1;
         if (cond_trn && branch_misprediction_i) miss_cnt_q  <= miss_cnt_q + 32'd1;
         if (btb_alloc)                          alloc_cnt_q <= alloc_cnt_q + 32'd1;
      end
   end

   assign perf_cond_cnt_o  = cond_cnt_q;
   assign perf_miss_cnt_o  = miss_cnt_q;
   assign perf_btb_alloc_o = alloc_cnt_q;
   assign unused_stat      = dec_is_branch_i & vld_d_q & hit_d_q & hit_e_q;
`else
   assign perf_cond_cnt_o  = '0;
   assign perf_miss_cnt_o  = '0;
   assign perf_btb_alloc_o = '0;
   assign unused_stat      = ^{dec_is_branch_i, vld_d_q, hit_d_q, hit_e_q,
                               branch_misprediction_i, btb_alloc};
`endif

endmodule

// File: tb/tb_bpu_gshare_btb.sv
// Directed bench for bpu_gshare_btb with hand-computed expectations.
// Perf-port expectations follow BPU_PERF_CNT_EN.
module tb_bpu_gshare_btb;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        stall_i, flush_i, dec_is_branch_i;
   logic        exe_is_branch_i, exe_is_jal_i, branch_taken_i, branch_misprediction_i;
   logic [31:0] pc_i, exe_pc_i, branch_target_addr_i;
   logic        branch_hit_o, branch_decision_o;
   logic [31:0] branch_target_addr_o, perf_cond_cnt_o, perf_miss_cnt_o, perf_btb_alloc_o;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned mis_cnt [1:4];

`ifdef BPU_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   bpu_gshare_btb #(
      .XLEN        (32),
      .ENTRY_NUM   (64),
      .PHT_ENTRIES (1024),
      .GHR_LEN     (8),
      .PC_LSB      (2)
   ) dut (
      .clk_i                  (clk_i),
      .rst_ni                 (rst_ni),
      .stall_i                (stall_i),
      .flush_i                (flush_i),
      .pc_i                   (pc_i),
      .dec_is_branch_i        (dec_is_branch_i),
      .exe_is_branch_i        (exe_is_branch_i),
      .exe_is_jal_i           (exe_is_jal_i),
      .exe_pc_i               (exe_pc_i),
      .branch_taken_i         (branch_taken_i),
      .branch_misprediction_i (branch_misprediction_i),
      .branch_target_addr_i   (branch_target_addr_i),
      .branch_hit_o           (branch_hit_o),
      .branch_decision_o      (branch_decision_o),
      .branch_target_addr_o   (branch_target_addr_o),
      .perf_cond_cnt_o        (perf_cond_cnt_o),
      .perf_miss_cnt_o        (perf_miss_cnt_o),
      .perf_btb_alloc_o       (perf_btb_alloc_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pexp(input int unsigned n);
      return PERF ? 32'(n) : 32'd0;
   endfunction

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr();
      exe_is_branch_i        = 1'b0;
      exe_is_jal_i           = 1'b0;
      branch_taken_i         = 1'b0;
      branch_misprediction_i = 1'b0;
      exe_pc_i               = '0;
      branch_target_addr_i   = '0;
   endtask

   task automatic exe(input logic [31:0] pc, input logic tk, input logic jal,
                      input logic mis, input logic [31:0] tgt);
      exe_is_branch_i        = 1'b1;
      exe_pc_i               = pc;
      branch_taken_i         = tk;
      exe_is_jal_i           = jal;
      branch_misprediction_i = mis;
      branch_target_addr_i   = tgt;
   endtask

   task automatic do_reset();
      @(posedge clk_i);
      #1;
      clr();
      stall_i = 1'b0;
      rst_ni  = 1'b0;
      cyc();
      rst_ni = 1'b1;
   endtask

   initial begin
      clr();
      stall_i         = 1'b0;
      flush_i         = 1'b1;
      dec_is_branch_i = 1'b0;
      pc_i            = 32'h100;
      rst_ni          = 1'b0;
      #3;
      check("rst_hit", 32'(branch_hit_o), 0);
      check("rst_dec", 32'(branch_decision_o), 0);
      check("rst_tgt", branch_target_addr_o, 0);
      check("rst_perf_cond", perf_cond_cnt_o, 0);
      cyc();
      rst_ni = 1'b1;

      // First allocation: miss this cycle, hit next cycle, counter still weak.
      pc_i = 32'h100; #2;
      check("cold_hit", 32'(branch_hit_o), 0);
      check("cold_tgt", branch_target_addr_o, 0);
      cyc();
      pc_i = 32'h200; exe(32'h200, 1, 0, 0, 32'h240); #2;
      check("alloc_same_cycle_hit", 32'(branch_hit_o), 0);
      cyc(); clr();
      pc_i = 32'h200; #2;
      check("alloc_hit", 32'(branch_hit_o), 1);
      check("alloc_tgt", branch_target_addr_o, 32'h240);
      check("alloc_dec", 32'(branch_decision_o), 0);

      // Pipelined index, flush, and stall.
      do_reset();
      flush_i = 1'b0;
      pc_i = 32'h204; cyc();
      pc_i = 32'h500; cyc();
      exe(32'h200, 1, 0, 0, 32'h240); cyc(); clr();
      pc_i = 32'h200; flush_i = 1'b1; #2;
      check("pipe_idx_hit", 32'(branch_hit_o), 1);
      check("pipe_idx_dec", 32'(branch_decision_o), 1);
      cyc();
      flush_i = 1'b0; pc_i = 32'h500; exe(32'h208, 1, 0, 0, 32'h260); cyc(); clr();
      flush_i = 1'b1; pc_i = 32'h200; #2;
      check("flush_recompute_dec", 32'(branch_decision_o), 1);
      cyc();
      stall_i = 1'b1;
      exe(32'h200, 0, 0, 1, 32'h300);
      for (int k = 0; k < 5; k++) begin
         pc_i = (k == 0) ? 32'h208 : 32'h200; #2;
         if (k == 0) begin
            check("stall_track_hit", 32'(branch_hit_o), 1);
            check("stall_track_tgt", branch_target_addr_o, 32'h260);
         end else if (k == 4) begin
            check("stall_track_dec", 32'(branch_decision_o), 1);
         end
         cyc();
      end
      stall_i = 1'b0; clr();
      pc_i = 32'h400; #1;
      check("stall_no_alloc", 32'(branch_hit_o), 0);
      pc_i = 32'h200; exe(32'h200, 0, 0, 0, 32'h240); #1;
      check("stall_hold_dec", 32'(branch_decision_o), 1);
      check("stall_hold_tgt", branch_target_addr_o, 32'h240);
      check("stall_perf_cond", perf_cond_cnt_o, pexp(2));
      check("stall_perf_miss", perf_miss_cnt_o, pexp(0));
      check("stall_perf_alloc", perf_btb_alloc_o, pexp(2));
      cyc(); clr();

      // Loop branch: 7 taken then exit, four iterations.
      do_reset();
      flush_i = 1'b1;
      for (int it = 1; it <= 4; it++) begin
         mis_cnt[it] = 0;
         for (int k = 1; k <= 8; k++) begin
            pc_i = 32'h300;
            exe(32'h300, (k < 8), 0, 0, 32'h2c0); #2;
            branch_misprediction_i = (branch_decision_o != (k < 8));
            if (branch_misprediction_i) mis_cnt[it]++;
            cyc();
         end
      end
      clr();
      check("loop_it2_miss", mis_cnt[2], 7);
      check("loop_it3_miss", mis_cnt[3], 0);
      check("loop_it4_miss", mis_cnt[4], 0);
      check("loop_perf_cond", perf_cond_cnt_o, pexp(32));
      check("loop_perf_miss", perf_miss_cnt_o, pexp(14));

      // Ten not-taken conditionals with three mispredicts.
      do_reset();
      for (int k = 0; k < 10; k++) begin
         exe(32'h700, 0, 0, (k == 1 || k == 4 || k == 7), 32'h740);
         cyc();
      end
      clr();
      pc_i = 32'h700; #1;
      check("nt_no_alloc", 32'(branch_hit_o), 0);
      check("perf_cond10", perf_cond_cnt_o, pexp(10));
      check("perf_miss3", perf_miss_cnt_o, pexp(3));
      check("perf_alloc0", perf_btb_alloc_o, pexp(0));

      // ENTRY_NUM+1 jal allocations wrap the pointer over entry 0.
      do_reset();
      for (int k = 0; k <= 64; k++) begin
         exe(32'h1000 + 32'(4 * k), 1, 1, 0, 32'h8000 + 32'(4 * k));
         cyc();
      end
      clr();
      pc_i = 32'h1000; #1;
      check("wrap_oldest_miss", 32'(branch_hit_o), 0);
      pc_i = 32'h1004; #1;
      check("wrap_k1_hit", 32'(branch_hit_o), 1);
      check("wrap_k1_tgt", branch_target_addr_o, 32'h8004);
      check("wrap_k1_jal_dec", 32'(branch_decision_o), 1);
      pc_i = 32'h1100; #1;
      check("wrap_k64_tgt", branch_target_addr_o, 32'h8100);
      check("wrap_perf_alloc", perf_btb_alloc_o, pexp(65));
      check("wrap_perf_cond", perf_cond_cnt_o, pexp(0));
      cyc();
      exe(32'h1004, 1, 1, 0, 32'h9000); cyc(); clr();
      pc_i = 32'h1004; #1;
      check("retarget_tgt", branch_target_addr_o, 32'h9000);
      exe(32'h2000, 1, 1, 0, 32'ha000); cyc(); clr();
      pc_i = 32'h1004; #1;
      check("retarget_ptr_still", 32'(branch_hit_o), 0);
      pc_i = 32'h2000; #1;
      check("alloc_at_ptr1_tgt", branch_target_addr_o, 32'ha000);
      pc_i = 32'h1008; #1;
      check("neighbour_hit", 32'(branch_hit_o), 1);
      cyc();
      exe(32'h0, 1, 1, 0, 32'h40); cyc(); clr();
      pc_i = 32'h0; #1;
      check("pc_zero_miss", 32'(branch_hit_o), 0);

      // Asynchronous reset mid-cycle clears everything immediately.
      pc_i = 32'h1008; #1;
      rst_ni = 1'b0; #1;
      check("async_rst_hit", 32'(branch_hit_o), 0);
      check("async_rst_tgt", branch_target_addr_o, 0);
      check("async_rst_alloc", perf_btb_alloc_o, 0);
      cyc();
      rst_ni = 1'b1; #1;
      check("post_rst_miss", 32'(branch_hit_o), 0);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
